// File: rtl/m72_video_timing.sv
// -----------------------------------------------------------------------------
// m72_video_timing
//
// Raster timing generator for the M72 core. It produces the pixel/line
// counters, the sync and blanking strobes, and the two CPU interrupt sources:
// vblank and raster compare (line interrupt).
//
// Ports:
//   pixel_clock  in   1  pixel clock, all logic on the rising edge
//   reset_n      in   1  asynchronous active-low reset
//   hcount       out  9  current pixel in the line
//   vcount       out  9  current line
//   hsync        out  1  horizontal sync, active high
//   vsync        out  1  vertical sync, active high
//   hblank       out  1  high while hcount >= H_VISIBLE
//   vblank       out  1  high while vcount >= V_VISIBLE
//   raster_wr    in   1  write strobe for the raster-compare register
//   raster_din   in  10  [9] enable, [8:0] compare line
//   int_req      out  1  an interrupt is pending
//   int_vector   out  8  vector of the highest-priority pending source
//   int_ack      in   1  acknowledge from the CPU interrupt cycle
// -----------------------------------------------------------------------------
module m72_video_timing #(
    parameter int          H_TOTAL    = 512,
    parameter int          H_VISIBLE  = 384,
    parameter int          HS_START   = 416,
    parameter int          HS_END     = 448,
    parameter int          V_TOTAL    = 284,
    parameter int          V_VISIBLE  = 256,
    parameter int          VS_START   = 268,
    parameter int          VS_END     = 271,
    parameter logic [7:0]  VBL_VECTOR = 8'h20,
    parameter logic [7:0]  RAS_VECTOR = 8'h22
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    output logic [8:0]  hcount,
    output logic [8:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    input  logic        raster_wr,
    input  logic [9:0]  raster_din,
    output logic        int_req,
    output logic [7:0]  int_vector,
    input  logic        int_ack
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_VIS  = 9'(H_VISIBLE);
    localparam logic [8:0] V_VIS  = 9'(V_VISIBLE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_END);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_END);

    logic [8:0] r_hcount;
    logic [8:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_hblank;
    logic       r_vblank;
    logic       r_ras_en;
    logic [8:0] r_ras_line;
    logic       r_vbl_pend;
    logic       r_ras_pend;
    logic       r_int_req;
    logic [7:0] r_int_vector;

    logic       w_h_wrap;
    logic [8:0] w_h_next;
    logic [8:0] w_v_next;
    logic       w_vbl_set;
    logic       w_ras_set;
    logic       w_ack_vbl;
    logic       w_ack_ras;
    logic       w_presented_pend;
    logic [7:0] w_vec_next;

    always_comb begin
        w_h_wrap = (r_hcount == H_LAST);
        w_h_next = w_h_wrap ? 9'd0 : r_hcount + 9'd1;
        w_v_next = r_vcount;
        if (w_h_wrap) begin
            w_v_next = (r_vcount == V_LAST) ? 9'd0 : r_vcount + 9'd1;
        end

        // Both events are decoded on the edge that moves the counters onto
        // the trigger position, so each fires exactly once per frame/line.
        w_vbl_set = w_h_wrap && (w_v_next == V_VIS);
        w_ras_set = r_ras_en && (w_h_next == H_VIS) && (w_v_next == r_ras_line);

        // An ack only clears the source the CPU actually saw in int_vector;
        // an ack while nothing is being requested is ignored.
        w_ack_vbl = int_ack && r_int_req && (r_int_vector == VBL_VECTOR);
        w_ack_ras = int_ack && r_int_req && (r_int_vector == RAS_VECTOR);

        // Hold the presented vector while its source is still being requested
        // so a late higher-priority source cannot change it under the CPU.
        w_presented_pend = (r_int_vector == VBL_VECTOR) ? r_vbl_pend : r_ras_pend;
        if ((r_int_req && w_presented_pend) || !(r_vbl_pend || r_ras_pend)) begin
            w_vec_next = r_int_vector;
        end else begin
            w_vec_next = r_vbl_pend ? VBL_VECTOR : RAS_VECTOR;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount     <= 9'd0;
            r_vcount     <= 9'd0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_hblank     <= 1'b0;
            r_vblank     <= 1'b0;
            r_ras_en     <= 1'b0;
            r_ras_line   <= 9'd0;
            r_vbl_pend   <= 1'b0;
            r_ras_pend   <= 1'b0;
            r_int_req    <= 1'b0;
            r_int_vector <= VBL_VECTOR;
        end else begin
            r_hcount <= w_h_next;
            r_vcount <= w_v_next;

            // Decoded from the next counter values so they line up with the
            // counters presented in the same cycle.
            r_hsync  <= (w_h_next >= HS_S) && (w_h_next < HS_E);
            r_vsync  <= (w_v_next >= VS_S) && (w_v_next < VS_E);
            r_hblank <= (w_h_next >= H_VIS);
            r_vblank <= (w_v_next >= V_VIS);

            // Compare above used the old register value in this same cycle.
            if (raster_wr) begin
                r_ras_en   <= raster_din[9];
                r_ras_line <= raster_din[8:0];
            end

            // Set wins over a coincident ack; a re-set while pending is a no-op.
            r_vbl_pend <= w_vbl_set || (r_vbl_pend && !w_ack_vbl);
            r_ras_pend <= w_ras_set || (r_ras_pend && !w_ack_ras);

            r_int_req    <= r_vbl_pend || r_ras_pend;
            r_int_vector <= w_vec_next;
        end
    end

    assign hcount     = r_hcount;
    assign vcount     = r_vcount;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign hblank     = r_hblank;
    assign vblank     = r_vblank;
    assign int_req    = r_int_req;
    assign int_vector = r_int_vector;

endmodule

// File: tb/tb_m72_video_timing.sv
// -----------------------------------------------------------------------------
// tb_m72_video_timing
//
// Directed bench for m72_video_timing with the default 512x284 raster.
// Each scenario task drives its own stimulus and checks against hand-computed
// values; outputs are sampled on the falling edge of pixel_clock.
// -----------------------------------------------------------------------------
module tb_m72_video_timing;

    localparam int FRAME   = 512 * 284;
    localparam int VBL_SET = 256 * 512;

    logic       pixel_clock;
    logic       reset_n;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       raster_wr;
    logic [9:0] raster_din;
    logic       int_req;
    logic [7:0] int_vector;
    logic       int_ack;

    int vectors;
    int miscompares;

    m72_video_timing dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .raster_wr   (raster_wr),
        .raster_din  (raster_din),
        .int_req     (int_req),
        .int_vector  (int_vector),
        .int_ack     (int_ack)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    task automatic step();
        @(posedge pixel_clock);
        @(negedge pixel_clock);
    endtask

    task automatic goto(input logic [8:0] hc, input logic [8:0] vc);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (hcount == hc && vcount == vc) break;
            step();
        end
        vectors++;
        if (!(hcount == hc && vcount == vc)) begin
            miscompares++;
            $display("FAIL goto: reached h=%0d v=%0d, required h=%0d v=%0d", hcount, vcount, hc, vc);
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic write_raster(input logic [9:0] d);
        raster_wr  = 1'b1;
        raster_din = d;
        step();
        raster_wr  = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic req, input logic [7:0] vec);
        vectors++;
        if (int_req !== req || (req && int_vector !== vec)) begin
            miscompares++;
            $display("FAIL %s: int_req=%0b vec=%02h, required int_req=%0b vec=%02h",
                     name, int_req, int_vector, req, vec);
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if ({hcount, vcount, hsync, vsync, hblank, vblank, int_req} !== 23'd0 ||
            int_vector !== 8'h20) begin
            miscompares++;
            $display("FAIL %s: h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b req=%0b vec=%02h, required all 0 vec=20",
                     name, hcount, vcount, hsync, vsync, hblank, vblank, int_req, int_vector);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        raster_wr  = 1'b0;
        raster_din = 10'd0;
        int_ack    = 1'b0;
        repeat (3) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_reset_values("reset_state");
    endtask

    // Full frame from reset release: counters, decodes and the first vblank.
    task automatic test_free_run();
        int err_cnt, err_hs, err_vs, err_hb, err_vb, err_req;
        int eh, ev;
        err_cnt = 0; err_hs = 0; err_vs = 0; err_hb = 0; err_vb = 0; err_req = 0;
        reset_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            eh = k % 512;
            ev = (k / 512) % 284;
            if (int'(hcount) != eh || int'(vcount) != ev) err_cnt++;
            if (hsync  !== (eh >= 416 && eh < 448)) err_hs++;
            if (vsync  !== (ev >= 268 && ev < 271)) err_vs++;
            if (hblank !== (eh >= 384)) err_hb++;
            if (vblank !== (ev >= 256)) err_vb++;
            if (k <= VBL_SET && int_req !== 1'b0) err_req++;
            if (k == FRAME - 1) begin
                vectors++;
                if (hcount !== 9'd511 || vcount !== 9'd283) begin
                    miscompares++;
                    $display("FAIL last_pixel: h=%0d v=%0d, required h=511 v=283", hcount, vcount);
                end
            end
            if (k == VBL_SET + 1) check_irq("vblank_set", 1'b1, 8'h20);
        end
        vectors++;
        if (hcount !== 9'd0 || vcount !== 9'd0) begin
            miscompares++;
            $display("FAIL frame_wrap: h=%0d v=%0d, required h=0 v=0", hcount, vcount);
        end
        vectors++;
        if (err_cnt != 0) begin miscompares++; $display("FAIL counters: %0d bad cycles, required 0", err_cnt); end
        vectors++;
        if (err_hs != 0) begin miscompares++; $display("FAIL hsync: %0d bad cycles, required 0", err_hs); end
        vectors++;
        if (err_vs != 0) begin miscompares++; $display("FAIL vsync: %0d bad cycles, required 0", err_vs); end
        vectors++;
        if (err_hb != 0) begin miscompares++; $display("FAIL hblank: %0d bad cycles, required 0", err_hb); end
        vectors++;
        if (err_vb != 0) begin miscompares++; $display("FAIL vblank: %0d bad cycles, required 0", err_vb); end
        vectors++;
        if (err_req != 0) begin miscompares++; $display("FAIL early_int_req: %0d bad cycles, required 0", err_req); end
    endtask

    // Vblank from frame 1 is still pending; ack lands on the frame-2 set edge.
    task automatic test_collision();
        goto(9'd511, 9'd255);
        pulse_ack();
        step();
        step();
        check_irq("set_ack_collision", 1'b1, 8'h20);
    endtask

    task automatic test_vblank_ack();
        pulse_ack();
        step();
        check_irq("vblank_ack", 1'b0, 8'h00);
    endtask

    task automatic test_raster();
        write_raster(10'h264);
        goto(9'd383, 9'd100);
        check_irq("raster_before", 1'b0, 8'h00);
        step();
        step();
        check_irq("raster_set", 1'b1, 8'h22);
        pulse_ack();
        step();
        check_irq("raster_ack", 1'b0, 8'h00);
    endtask

    task automatic test_priority();
        write_raster(10'h300);
        goto(9'd0, 9'd256);
        step();
        check_irq("prio_vblank", 1'b1, 8'h20);
        goto(9'd386, 9'd256);
        check_irq("prio_both_pending", 1'b1, 8'h20);
        pulse_ack();
        step();
        check_irq("prio_switch", 1'b1, 8'h22);
        pulse_ack();
        step();
        check_irq("prio_all_acked", 1'b0, 8'h00);
    endtask

    task automatic test_raster_disabled();
        int hits;
        hits = 0;
        write_raster(10'h064);
        goto(9'd383, 9'd100);
        for (int i = 0; i < 300; i++) begin
            step();
            if (int_req !== 1'b0) hits++;
        end
        vectors++;
        if (hits != 0) begin
            miscompares++;
            $display("FAIL raster_disabled: int_req high %0d cycles, required 0", hits);
        end
    endtask

    task automatic test_reset_mid();
        goto(9'd420, 9'd256);
        check_irq("pre_reset_pending", 1'b1, 8'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_reset_values("reset_held");
        reset_n = 1'b1;
    endtask

    // Enabled compare on line 300 must never fire; only the vblank appears.
    task automatic test_out_of_range();
        int stray;
        stray = 0;
        raster_wr  = 1'b1;
        raster_din = 10'h32C;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            raster_wr = 1'b0;
            int_ack   = 1'b0;
            if (k == VBL_SET + 1) begin
                check_irq("oor_vblank", 1'b1, 8'h20);
                int_ack = 1'b1;
            end else if (k != VBL_SET + 2 && int_req !== 1'b0) begin
                stray++;
            end
        end
        int_ack = 1'b0;
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL out_of_range_line: int_req high %0d cycles, required 0", stray);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_free_run();
        test_collision();
        test_vblank_ack();
        test_raster();
        test_priority();
        test_raster_disabled();
        test_reset_mid();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
